// File: rtl/ped_pkg.sv
// rtl/ped_pkg.sv - shared types and constants for the pedestrian call scheduler
//
// Purpose: light codes, scheduler state encoding, crosswalk indices and the
//          round-robin pick helper used by ped_call_scheduler.
// Ports:   none (package).

package ped_pkg;

    // Light codes consumed by the semaforo2 decoders; 2'd3 is never driven.
    localparam logic [1:0] RED   = 2'd0;
    localparam logic [1:0] GREEN = 2'd1;
    localparam logic [1:0] BLINK = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WALK,
        CLEAR,
        GAP
    } state_t;

    // Crosswalk indices, also the bit positions in the pending vector.
    localparam logic [1:0] N   = 2'd0;
    localparam logic [1:0] TH1 = 2'd1;
    localparam logic [1:0] TH2 = 2'd2;

    // First set request strictly after 'last', scanning N -> TH1 -> TH2 -> N.
    // When only 'last' itself is requesting, the scan wraps back onto it.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        idx   = last;
        pick  = last;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == TH2) ? N : idx + 2'd1;
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ped_debounce.sv
// rtl/ped_debounce.sv - push-button debouncer with filtered rising-edge pulse
//
// Purpose: the filtered level follows the raw input only after it has held the
//          new level for DEBOUNCE_TICKS consecutive cycles.
// Ports:   clk   - system clock
//          reset - asynchronous active-high reset (filter cleared to 0)
//          raw   - raw button level
//          filt  - debounced level
//          rise  - one-cycle pulse coincident with filt going 0 -> 1

module ped_debounce #(
    parameter int DEBOUNCE_TICKS = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;

    logic          filt_q, filt_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt counts consecutive cycles the raw level has differed from filt;
    // any return to the filtered level restarts the count.
    always_comb begin
        filt_d = filt_q;
        rise_d = 1'b0;
        cnt_d  = '0;
        if (raw != filt_q) begin
            if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                filt_d = raw;
                rise_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt = filt_q;
    assign rise = rise_q;

endmodule

// File: rtl/ped_call_scheduler.sv
// rtl/ped_call_scheduler.sv - pedestrian call latching, arbitration and walk sequencing
//
// Purpose: debounces the three crosswalk buttons, latches calls, picks the next
//          crosswalk round-robin, obtains a safe window from the main fsm and
//          runs WALK / CLEAR / GAP on a single seconds-derived down-counter.
// Ports:   clk, reset                  - clock, asynchronous active-high reset
//          enable                      - scheduler enable
//          btn_n, btn_th1, btn_th2     - raw push buttons
//          safe_ack                    - conflicting vehicle phases are red
//          ped_req                     - request / hold of the safe window
//          light_pn, light_pth1, light_pth2 - 2-bit light codes
//          pending                     - latched calls {th2,th1,n}
//          busy                        - high in WALK or CLEAR
//          done                        - one-cycle pulse on the last CLEAR cycle

module ped_call_scheduler
    import ped_pkg::*;
#(
    parameter int TICKS_PER_SEC  = 10000,
    parameter int WALK_SEC       = 8,
    parameter int CLEAR_SEC      = 4,
    parameter int GAP_SEC        = 2,
    parameter int DEBOUNCE_TICKS = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_n,
    input  logic       btn_th1,
    input  logic       btn_th2,
    input  logic       safe_ack,
    output logic       ped_req,
    output logic [1:0] light_pn,
    output logic [1:0] light_pth1,
    output logic [1:0] light_pth2,
    output logic [2:0] pending,
    output logic       busy,
    output logic       done
);

    localparam int WALK_CYC  = WALK_SEC * TICKS_PER_SEC;
    localparam int CLEAR_CYC = CLEAR_SEC * TICKS_PER_SEC;
    localparam int GAP_CYC   = GAP_SEC * TICKS_PER_SEC;
    localparam int MAX_WC    = (WALK_CYC > CLEAR_CYC) ? WALK_CYC : CLEAR_CYC;
    localparam int MAX_CYC   = (MAX_WC > GAP_CYC) ? MAX_WC : GAP_CYC;
    localparam int TW        = $clog2(MAX_CYC) + 1;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    pending_q, pending_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    grant;
    logic          grant_fire;
    logic [2:0]    btn_raw;
    logic [2:0]    rise;
    logic [1:0]    served_code;

    assign btn_raw = {btn_th2, btn_th1, btn_n};

    for (genvar g = 0; g < 3; g++) begin : g_deb
        ped_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (btn_raw[g]),
            .filt  (),
            .rise  (rise[g])
        );
    end

    assign grant = rr_pick(pending_q, last_q);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Once WALK is entered the sequence always runs through
    // CLEAR and GAP, whatever enable does, so nobody is cut off mid-crossing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable && (|pending_q)) state_d = REQ;
            end
            REQ: begin
                if (!enable || (pending_q == 3'b000)) state_d = IDLE;
                else if (safe_ack)                    state_d = WALK;
            end
            WALK: begin
                if ((timer_q == '0) || !safe_ack) state_d = CLEAR;
            end
            CLEAR: begin
                if (timer_q == '0) state_d = GAP;
            end
            GAP: begin
                if (timer_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ped_req     = (state_q == REQ) || (state_q == WALK) || (state_q == CLEAR);
        busy        = (state_q == WALK) || (state_q == CLEAR);
        done        = (state_q == CLEAR) && (timer_q == '0);
        served_code = (state_q == WALK) ? GREEN : ((state_q == CLEAR) ? BLINK : RED);
        light_pn    = RED;
        light_pth1  = RED;
        light_pth2  = RED;
        // last_q holds the crosswalk being served from WALK entry onward.
        case (last_q)
            N:       light_pn   = served_code;
            TH1:     light_pth1 = served_code;
            TH2:     light_pth2 = served_code;
            default: ;
        endcase
    end

    assign pending = pending_q;

    // Timer, call latches and round-robin pointer
    always_comb begin
        grant_fire = (state_q == REQ) && (state_d == WALK);
        last_d     = grant_fire ? grant : last_q;

        // Load on every state change (including the WALK abort into CLEAR);
        // the state ends on the cycle the counter reads zero.
        if (state_d != state_q) begin
            case (state_d)
                WALK:    timer_d = TW'(WALK_CYC - 1);
                CLEAR:   timer_d = TW'(CLEAR_CYC - 1);
                GAP:     timer_d = TW'(GAP_CYC - 1);
                default: timer_d = '0;
            endcase
        end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end else begin
            timer_d = timer_q;
        end

        pending_d = pending_q;
        if (grant_fire) pending_d[grant] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // A press for the crosswalk that is already walking is redundant.
            if (rise[i] && !((state_q == WALK) && (last_q == 2'(i)))) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q   <= '0;
            pending_q <= 3'b000;
            last_q    <= TH2;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_ped_call_scheduler.sv
// tb/tb_ped_call_scheduler.sv - directed self-checking bench for ped_call_scheduler

module tb_ped_call_scheduler;
    import ped_pkg::*;

    localparam int TPS = 4;
    localparam int WS  = 3;
    localparam int CS  = 2;
    localparam int GS  = 1;
    localparam int DB  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       btn_n;
    logic       btn_th1;
    logic       btn_th2;
    logic       safe_ack;
    logic       ped_req;
    logic [1:0] light_pn;
    logic [1:0] light_pth1;
    logic [1:0] light_pth2;
    logic [2:0] pending;
    logic       busy;
    logic       done;

    ped_call_scheduler #(
        .TICKS_PER_SEC  (TPS),
        .WALK_SEC       (WS),
        .CLEAR_SEC      (CS),
        .GAP_SEC        (GS),
        .DEBOUNCE_TICKS (DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .btn_n      (btn_n),
        .btn_th1    (btn_th1),
        .btn_th2    (btn_th2),
        .safe_ack   (safe_ack),
        .ped_req    (ped_req),
        .light_pn   (light_pn),
        .light_pth1 (light_pth1),
        .light_pth2 (light_pth2),
        .pending    (pending),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] light_of(input int idx);
        case (idx)
            0:       return light_pn;
            1:       return light_pth1;
            default: return light_pth2;
        endcase
    endfunction

    // Hold the buttons in mask m just long enough for the filter to rise;
    // returns on the sample where the filtered edge has just registered.
    task automatic press(input logic [2:0] m);
        {btn_th2, btn_th1, btn_n} = m;
        repeat (DB) tick();
        {btn_th2, btn_th1, btn_n} = 3'b000;
    endtask

    task automatic do_reset();
        {btn_th2, btn_th1, btn_n} = 3'b000;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_light(input string tag, input int idx, input logic [1:0] code,
                              input int maxc, output int n);
        n = 0;
        while (light_of(idx) != code && n < maxc) begin
            tick();
            n++;
        end
        check(tag, 32'(light_of(idx) == code), 1);
    endtask

    task automatic count_light(input int idx, input logic [1:0] code, input int maxc,
                               output int n, output int done_at);
        n       = 0;
        done_at = -1;
        while (light_of(idx) == code && n < maxc) begin
            if (done) done_at = n;
            n++;
            tick();
        end
    endtask

    int         n;
    int         da;
    int         order [3];
    int         nserv;
    int         overlap;
    int         badcode;
    int         dones;
    int         lowrun;
    int         gaplen;
    int         nonred;
    logic [2:0] gmask;
    logic [2:0] prev_g;
    logic [2:0] pend_first;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        safe_ack = 1'b0;
        {btn_th2, btn_th1, btn_n} = 3'b000;
        #2;
        check("rst_light_pn", light_pn, RED);
        check("rst_light_pth1", light_pth1, RED);
        check("rst_light_pth2", light_pth2, RED);
        check("rst_pending", pending, 3'b000);
        check("rst_ped_req", ped_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // 1: short glitch rejected, full-length press latched
        enable = 1'b1;
        btn_n  = 1'b1;
        repeat (2) tick();
        btn_n = 1'b0;
        repeat (4) tick();
        check("t1_glitch_pending", pending, 3'b000);
        check("t1_glitch_req", ped_req, 0);
        btn_n = 1'b1;
        repeat (3) tick();
        check("t1_pend_at_rise", pending, 3'b000);
        tick();
        check("t1_pend_set", pending, 3'b001);
        check("t1_req_not_yet", ped_req, 0);
        tick();
        check("t1_req", ped_req, 1);
        btn_n = 1'b0;
        repeat (3) tick();
        check("t1_req_hold", ped_req, 1);
        check("t1_red_wait", light_pn, RED);

        // 2: full service of N
        safe_ack = 1'b1;
        tick();
        check("t2_walk_green", light_pn, GREEN);
        check("t2_pending_clr", pending, 3'b000);
        check("t2_busy", busy, 1);
        count_light(0, GREEN, 50, n, da);
        check("t2_walk_len", n, WS * TPS);
        count_light(0, BLINK, 50, n, da);
        check("t2_clear_len", n, CS * TPS);
        check("t2_done_pos", da, CS * TPS - 1);
        check("t2_gap_red", light_pn, RED);
        check("t2_gap_req", ped_req, 0);
        check("t2_gap_busy", busy, 0);
        check("t2_gap_done", done, 0);
        repeat (8) tick();
        check("t2_idle_req", ped_req, 0);

        // 3: all three pending, round-robin from last=TH2
        do_reset();
        enable   = 1'b1;
        safe_ack = 1'b1;
        press(3'b111);
        nserv = 0; overlap = 0; badcode = 0; dones = 0;
        lowrun = 0; gaplen = -1; prev_g = 3'b000; pend_first = 3'b111;
        for (int c = 0; c < 120; c++) begin
            tick();
            gmask = {light_pth2 == GREEN, light_pth1 == GREEN, light_pn == GREEN};
            for (int k = 0; k < 3; k++) begin
                if (gmask[k] && !prev_g[k]) begin
                    if (nserv < 3) order[nserv] = k;
                    if (nserv == 0) pend_first = pending;
                    nserv++;
                end
            end
            prev_g = gmask;
            nonred = int'(light_pn != RED) + int'(light_pth1 != RED) + int'(light_pth2 != RED);
            if (nonred > 1) overlap++;
            if (light_pn == 2'd3 || light_pth1 == 2'd3 || light_pth2 == 2'd3) badcode++;
            if (!ped_req) begin
                lowrun++;
            end else begin
                if (dones >= 1 && gaplen < 0) gaplen = lowrun;
                lowrun = 0;
            end
            if (done) dones++;
        end
        check("t3_services", nserv, 3);
        check("t3_order0", order[0], 0);
        check("t3_order1", order[1], 1);
        check("t3_order2", order[2], 2);
        check("t3_pend_first_walk", pend_first, 3'b110);
        check("t3_overlap", overlap, 0);
        check("t3_code3", badcode, 0);
        check("t3_dones", dones, 3);
        check("t3_gap_plus_idle", gaplen, GS * TPS + 1);

        // 4: safe_ack lost in the 5th WALK cycle
        do_reset();
        enable   = 1'b1;
        safe_ack = 1'b1;
        press(3'b001);
        wait_light("t4_wait_walk", 0, GREEN, 20, n);
        repeat (4) tick();
        check("t4_walk5", light_pn, GREEN);
        safe_ack = 1'b0;
        tick();
        check("t4_abort_blink", light_pn, BLINK);
        count_light(0, BLINK, 50, n, da);
        check("t4_clear_len", n, CS * TPS);
        check("t4_done_pos", da, CS * TPS - 1);

        // 5: press absorbed during own WALK, latched during CLEAR
        do_reset();
        enable   = 1'b1;
        safe_ack = 1'b1;
        press(3'b010);
        wait_light("t5_wait_walk", 1, GREEN, 20, n);
        check("t5_walk_latency", n, 3);
        press(3'b010);
        repeat (2) tick();
        check("t5_absorb", pending, 3'b000);
        check("t5_still_walk", light_pth1, GREEN);
        wait_light("t5_wait_clear", 1, BLINK, 20, n);
        press(3'b010);
        tick();
        check("t5_clear_latch", pending, 3'b010);
        check("t5_still_clear", light_pth1, BLINK);
        wait_light("t5_wait_reserve", 1, GREEN, 30, n);
        check("t5_reserve_lat", n, 10);
        check("t5_reserve_pend", pending, 3'b000);

        // 6: asynchronous reset mid-WALK
        do_reset();
        enable   = 1'b1;
        safe_ack = 1'b1;
        press(3'b011);
        wait_light("t6_wait_walk", 0, GREEN, 20, n);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("t6_async_pn", light_pn, RED);
        check("t6_async_req", ped_req, 0);
        check("t6_async_pend", pending, 3'b000);
        check("t6_async_busy", busy, 0);
        reset = 1'b0;
        repeat (10) tick();
        check("t6_idle_req", ped_req, 0);
        check("t6_idle_pend", pending, 3'b000);
        press(3'b100);
        wait_light("t6_new_walk", 2, GREEN, 20, n);
        check("t6_new_latency", n, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
